// File: rtl/h75_pkg.sv
// Shared widths and write-side FSM state encoding for the HUB75 frame-buffer writer.
package h75_pkg;

    localparam int unsigned H75_DATA_W = 32;
    localparam int unsigned H75_OFF_W  = 14;
    localparam int unsigned H75_ADDR_W = H75_OFF_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        WAIT_SWAP
    } fbw_state_t;

endpackage

// File: rtl/h75_sync_fifo.sv
// Single-clock FIFO with show-ahead read data; depth must be a power of two.
module h75_sync_fifo
    import h75_pkg::*;
#(
    parameter int unsigned WIDTH = H75_DATA_W,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [PTR_W:0]   count
);

    localparam logic [PTR_W:0] CNT_ONE  = 1;
    localparam logic [PTR_W:0] CNT_FULL = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wptr_q, rptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_push, do_pop;

    assign full    = (count_q == CNT_FULL);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem[rptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage carries no reset; only pointers and count define contents.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (do_pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/h75_fb_writer.sv
// Buffers pixel words and writes them into the back bank of a double-buffered frame memory,
// swapping banks on frame_sync once a committed frame has fully drained.
module h75_fb_writer
    import h75_pkg::*;
#(
    parameter int unsigned DATA_W     = H75_DATA_W,
    parameter int unsigned OFF_W      = H75_OFF_W,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    input  logic [OFF_W-1:0]  frame_words,
    input  logic              addr_load,
    input  logic [OFF_W-1:0]  addr_load_val,
    input  logic              commit,
    input  logic              frame_sync,
    input  logic              clear_ovf,
    output logic              mem_wr,
    output logic [OFF_W:0]    mem_waddr,
    output logic [DATA_W-1:0] mem_data,
    output logic              disp_bank,
    output logic              busy,
    output logic              overflow
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    fbw_state_t        state_q;
    logic [OFF_W-1:0]  offset_q;
    logic              disp_bank_q;
    logic              mem_wr_q;
    logic [OFF_W:0]    mem_waddr_q;
    logic [DATA_W-1:0] mem_data_q;
    logic              overflow_q;

    logic              fifo_full, fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [DATA_W-1:0] fifo_rdata;
    logic              push, pop, swap, load;
    logic [OFF_W-1:0]  last_off, off_inc;

    assign s_ready = !fifo_full && (state_q != WAIT_SWAP);
    assign push    = s_valid && s_ready;
    // Popping straight out of IDLE keeps accept-to-write latency at two cycles.
    assign pop     = !fifo_empty;
    assign swap    = (state_q == WAIT_SWAP) && frame_sync && fifo_empty && !mem_wr_q;
    assign load    = addr_load && (state_q != WAIT_SWAP);

    // frame_words == 0 underflows to all-ones, i.e. a full 2^OFF_W bank.
    assign last_off = frame_words - OFF_W'(1);
    assign off_inc  = (offset_q == last_off) ? '0 : offset_q + OFF_W'(1);

    h75_sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (push),
        .wdata  (s_data),
        .pop    (pop),
        .rdata  (fifo_rdata),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            offset_q    <= '0;
            disp_bank_q <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_waddr_q <= '0;
            mem_data_q  <= '0;
            overflow_q  <= 1'b0;
        end else begin
            mem_wr_q <= pop;
            if (pop) begin
                mem_waddr_q <= {~disp_bank_q, offset_q};
                mem_data_q  <= fifo_rdata;
            end

            if (swap) begin
                offset_q <= '0;
            end else if (load) begin
                offset_q <= addr_load_val;
            end else if (pop) begin
                offset_q <= off_inc;
            end

            if (swap) begin
                disp_bank_q <= ~disp_bank_q;
            end

            if (s_valid && !s_ready) begin
                overflow_q <= 1'b1;
            end else if (clear_ovf) begin
                overflow_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (commit) begin
                        state_q <= WAIT_SWAP;
                    end else if (!fifo_empty) begin
                        state_q <= WRITE;
                    end
                end
                WRITE: begin
                    if (commit) begin
                        state_q <= WAIT_SWAP;
                    end else if (fifo_empty) begin
                        state_q <= IDLE;
                    end
                end
                WAIT_SWAP: begin
                    if (swap) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_wr    = mem_wr_q;
    assign mem_waddr = mem_waddr_q;
    assign mem_data  = mem_data_q;
    assign disp_bank = disp_bank_q;
    assign overflow  = overflow_q;
    assign busy      = (state_q != IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_h75_fb_writer.sv
// Directed self-checking bench for h75_fb_writer: latency, wrap, overflow, bank swap and reset.
module tb_h75_fb_writer;

    logic        clk;
    logic        resetn;
    logic        s_valid;
    logic [31:0] s_data;
    logic        s_ready;
    logic [13:0] frame_words;
    logic        addr_load;
    logic [13:0] addr_load_val;
    logic        commit;
    logic        frame_sync;
    logic        clear_ovf;
    logic        mem_wr;
    logic [14:0] mem_waddr;
    logic [31:0] mem_data;
    logic        disp_bank;
    logic        busy;
    logic        overflow;

    int checks;
    int failures;

    logic [14:0] wq [$];
    logic [31:0] dq [$];

    h75_fb_writer dut (
        .clk           (clk),
        .resetn        (resetn),
        .s_valid       (s_valid),
        .s_data        (s_data),
        .s_ready       (s_ready),
        .frame_words   (frame_words),
        .addr_load     (addr_load),
        .addr_load_val (addr_load_val),
        .commit        (commit),
        .frame_sync    (frame_sync),
        .clear_ovf     (clear_ovf),
        .mem_wr        (mem_wr),
        .mem_waddr     (mem_waddr),
        .mem_data      (mem_data),
        .disp_bank     (disp_bank),
        .busy          (busy),
        .overflow      (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and log any memory write seen just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (mem_wr === 1'b1) begin
            wq.push_back(mem_waddr);
            dq.push_back(mem_data);
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_log();
        wq.delete();
        dq.delete();
    endtask

    function automatic logic [31:0] log_addr(input int i);
        if (i < wq.size()) return 32'(wq[i]);
        return 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] log_data(input int i);
        if (i < dq.size()) return dq[i];
        return 32'hDEAD_BEEF;
    endfunction

    task automatic do_reset();
        s_valid    = 1'b0;
        commit     = 1'b0;
        frame_sync = 1'b0;
        clear_ovf  = 1'b0;
        addr_load  = 1'b0;
        resetn     = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        clear_log();
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        s_data        = '0;
        frame_words   = 14'd4;
        addr_load_val = '0;
        do_reset();

        // Reset state
        chk("rst_mem_wr", 32'(mem_wr), 32'd0);
        chk("rst_mem_waddr", 32'(mem_waddr), 32'd0);
        chk("rst_mem_data", mem_data, 32'd0);
        chk("rst_disp_bank", 32'(disp_bank), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_s_ready", 32'(s_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);

        // Three back-to-back words: first write two cycles after acceptance
        s_valid = 1'b1; s_data = 32'hA1; tick();
        chk("lat_no_wr_yet", 32'(mem_wr), 32'd0);
        s_data = 32'hA2; tick();
        chk("lat_wr0", 32'(mem_wr), 32'd1);
        chk("lat_addr0", 32'(mem_waddr), 32'h4000);
        chk("lat_data0", mem_data, 32'hA1);
        s_data = 32'hA3; tick();
        chk("lat_addr1", 32'(mem_waddr), 32'h4001);
        chk("lat_data1", mem_data, 32'hA2);
        s_valid = 1'b0; tick();
        chk("lat_addr2", 32'(mem_waddr), 32'h4002);
        chk("lat_data2", mem_data, 32'hA3);
        chk("lat_busy_hold", 32'(busy), 32'd1);
        tick();
        chk("lat_wr_done", 32'(mem_wr), 32'd0);
        chk("lat_busy_fall", 32'(busy), 32'd0);

        // Wrap at frame_words=4
        addr_load = 1'b1; addr_load_val = 14'd0; tick();
        addr_load = 1'b0;
        clear_log();
        for (int i = 0; i < 6; i++) begin
            s_valid = 1'b1; s_data = 32'hB0 + 32'(i); tick();
        end
        s_valid = 1'b0; ticks(4);
        chk("wrap_count", 32'(wq.size()), 32'd6);
        chk("wrap_a0", log_addr(0), 32'h4000);
        chk("wrap_a3", log_addr(3), 32'h4003);
        chk("wrap_a4", log_addr(4), 32'h4000);
        chk("wrap_a5", log_addr(5), 32'h4001);
        chk("wrap_d5", log_data(5), 32'hB5);

        // frame_words=0 means a full 2^14 bank
        frame_words = 14'd0;
        addr_load = 1'b1; addr_load_val = 14'h3FFF; tick();
        addr_load = 1'b0;
        clear_log();
        s_valid = 1'b1; s_data = 32'hC0; tick();
        s_data = 32'hC1; tick();
        s_valid = 1'b0; ticks(4);
        chk("full_count", 32'(wq.size()), 32'd2);
        chk("full_a0", log_addr(0), 32'h7FFF);
        chk("full_a1", log_addr(1), 32'h4000);

        // Overflow while parked in WAIT_SWAP
        clear_log();
        commit = 1'b1; tick();
        commit = 1'b0;
        chk("ovf_s_ready", 32'(s_ready), 32'd0);
        for (int i = 0; i < 12; i++) begin
            s_valid = 1'b1; s_data = 32'hD0 + 32'(i); tick();
        end
        chk("ovf_set", 32'(overflow), 32'd1);
        clear_ovf = 1'b1; tick();
        chk("ovf_set_wins", 32'(overflow), 32'd1);
        s_valid = 1'b0; tick();
        clear_ovf = 1'b0;
        chk("ovf_cleared", 32'(overflow), 32'd0);
        chk("ovf_no_writes", 32'(wq.size()), 32'd0);
        frame_sync = 1'b1; tick();
        frame_sync = 1'b0;
        chk("ovf_swap_bank", 32'(disp_bank), 32'd1);
        chk("ovf_swap_ready", 32'(s_ready), 32'd1);

        // Commit with data in flight: first sync ignored, second swaps
        do_reset();
        frame_words = 14'd0;
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1; s_data = 32'hE0 + 32'(i);
            commit = (i == 4);
            tick();
        end
        s_valid = 1'b0; commit = 1'b0;
        frame_sync = 1'b1; tick();
        frame_sync = 1'b0;
        chk("swap_early_ignored", 32'(disp_bank), 32'd0);
        ticks(19);
        chk("swap_still_waiting", 32'(disp_bank), 32'd0);
        frame_sync = 1'b1; tick();
        frame_sync = 1'b0;
        chk("swap_toggled", 32'(disp_bank), 32'd1);
        chk("swap_count", 32'(wq.size()), 32'd5);
        chk("swap_a4", log_addr(4), 32'h4004);
        chk("swap_d4", log_data(4), 32'hE4);
        clear_log();
        s_valid = 1'b1; s_data = 32'hF00D; tick();
        s_valid = 1'b0; ticks(3);
        chk("post_swap_addr", log_addr(0), 32'h0000);
        chk("post_swap_data", log_data(0), 32'hF00D);

        // Asynchronous reset in WAIT_SWAP with words still queued
        clear_log();
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1; s_data = 32'h90 + 32'(i);
            commit = (i == 3);
            tick();
        end
        s_valid = 1'b0; commit = 1'b0;
        chk("arst_pre_wr", 32'(mem_wr), 32'd1);
        resetn = 1'b0;
        #1;
        chk("arst_mem_wr", 32'(mem_wr), 32'd0);
        chk("arst_mem_waddr", 32'(mem_waddr), 32'd0);
        chk("arst_mem_data", mem_data, 32'd0);
        chk("arst_disp_bank", 32'(disp_bank), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        clear_log();
        ticks(3);
        chk("arst_no_writes", 32'(wq.size()), 32'd0);
        chk("arst_s_ready", 32'(s_ready), 32'd1);
        chk("arst_bank_kept", 32'(disp_bank), 32'd0);

        // commit coincident with frame_sync does not swap
        commit = 1'b1; frame_sync = 1'b1; tick();
        commit = 1'b0; frame_sync = 1'b0;
        chk("coinc_no_swap", 32'(disp_bank), 32'd0);
        chk("coinc_waiting", 32'(s_ready), 32'd0);
        ticks(2);
        frame_sync = 1'b1; tick();
        frame_sync = 1'b0;
        chk("coinc_next_swap", 32'(disp_bank), 32'd1);
        chk("coinc_idle_ready", 32'(s_ready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
